// File: rtl/mem_sync_sp_pkg.sv
// Shared types for the single-port memory load/store unit.
package mem_sync_sp_pkg;

   typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;

   typedef enum logic [2:0] {IDLE = 3'd0, ACC0 = 3'd1, ACC1 = 3'd2, CAP = 3'd3, RESP = 3'd4} lsu_state_e;

   function automatic logic [3:0] size_bytes(size_e s);
      return 4'd1 << s;
   endfunction

endpackage

// File: rtl/mem_sync_sp_lsu_if.sv
// Request/response channel between a requester (master) and the LSU (slave).
interface mem_sync_sp_lsu_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int BADDR_WIDTH = 14
);
   // Both channels: a transfer happens on a posedge where valid & ready are both 1;
   // the sender holds valid and its payload unchanged until that transfer.
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_we;
   logic [1:0]             req_size;
   logic                   req_signed;
   logic [BADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0]  req_wdata;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [DATA_WIDTH-1:0]  rsp_rdata;
   logic                   rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: write masks, store data shifts, load extract and extend.
module mem_lane_align
   import mem_sync_sp_pkg::*;
#(
   parameter  int DATA_WIDTH = 64,
   localparam int DATA_BYTES = DATA_WIDTH / 8,
   localparam int OFF_W      = $clog2(DATA_BYTES)
) (
   input  logic [OFF_W-1:0]        i_off,
   input  size_e                   i_size,
   input  logic                    i_signed,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [2*DATA_WIDTH-1:0] i_ld_word,
   output logic [DATA_BYTES-1:0]   o_wen0,
   output logic [DATA_BYTES-1:0]   o_wen1,
   output logic [DATA_WIDTH-1:0]   o_wdata0,
   output logic [DATA_WIDTH-1:0]   o_wdata1,
   output logic [DATA_WIDTH-1:0]   o_ld_data
);
   logic [3:0]              w_nbytes;
   logic [2*DATA_WIDTH-1:0] w_st;
   logic [DATA_WIDTH-1:0]   w_sh;
   logic                    w_sign;

   assign w_nbytes = size_bytes(i_size);

   // Store data shifted across a two-word window: low half feeds word0, high half word1.
   assign w_st     = {{DATA_WIDTH{1'b0}}, i_wdata} << {i_off, 3'b000};
   assign o_wdata0 = w_st[DATA_WIDTH-1:0];
   assign o_wdata1 = w_st[2*DATA_WIDTH-1:DATA_WIDTH];
   assign w_sh     = i_ld_word[{i_off, 3'b000} +: DATA_WIDTH];

   always_comb begin
      o_wen0    = '0;
      o_wen1    = '0;
      o_ld_data = '0;
      w_sign    = 1'b0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (i >= int'(i_off) && i < int'(i_off) + int'(w_nbytes)) o_wen0[i] = 1'b1;
         if (i + DATA_BYTES < int'(i_off) + int'(w_nbytes)) o_wen1[i] = 1'b1;
         if (i == int'(w_nbytes) - 1) w_sign = w_sh[8*i+7];
      end
      for (int i = 0; i < DATA_BYTES; i++) begin
         o_ld_data[8*i +: 8] = (i < int'(w_nbytes)) ? w_sh[8*i +: 8] : {8{i_signed & w_sign}};
      end
   end
endmodule

// File: rtl/mem_sync_sp_lsu.sv
// Load/store initiator for a 1-cycle synchronous single-port memory; splits
// word-crossing accesses into two memory cycles, one request in flight.
module mem_sync_sp_lsu
   import mem_sync_sp_pkg::*;
#(
   parameter  int DEPTH       = 2048,
   parameter  int DATA_WIDTH  = 64,
   localparam int DATA_BYTES  = DATA_WIDTH / 8,
   localparam int ADDR_WIDTH  = $clog2(DEPTH),
   localparam int OFF_W       = $clog2(DATA_BYTES),
   localparam int BADDR_WIDTH = ADDR_WIDTH + OFF_W
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_sync_sp_lsu_if.slave      bus,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [DATA_BYTES-1:0] mem_wen,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output lsu_state_e            dbg_state
);
   localparam logic [BADDR_WIDTH:0] LIMIT = (BADDR_WIDTH+1)'(DEPTH * DATA_BYTES);

   lsu_state_e            r_state;
   logic                  r_req_ready, r_rsp_valid, r_rsp_err;
   logic [DATA_WIDTH-1:0] r_rsp_rdata, r_mem_wdata, r_wdata, r_lo;
   logic [ADDR_WIDTH-1:0] r_mem_addr, r_w0;
   logic                  r_we, r_signed, r_split;
   size_e                 r_size;
   logic [OFF_W-1:0]      r_off;

   logic [OFF_W-1:0]        w_req_off, w_al_off;
   logic [ADDR_WIDTH-1:0]   w_req_w0;
   logic [3:0]              w_req_nbytes;
   logic [BADDR_WIDTH:0]    w_req_end;
   logic                    w_req_err, w_req_split, w_idle;
   size_e                   w_al_size;
   logic [DATA_WIDTH-1:0]   w_al_wdata, w_wdata0, w_wdata1, w_ld_data;
   logic [DATA_BYTES-1:0]   w_wen0, w_wen1;
   logic [2*DATA_WIDTH-1:0] w_ld_word;

   assign w_req_off    = bus.req_addr[OFF_W-1:0];
   assign w_req_w0     = bus.req_addr[BADDR_WIDTH-1:OFF_W];
   assign w_req_nbytes = size_bytes(size_e'(bus.req_size));
   assign w_req_end    = {1'b0, bus.req_addr} + (BADDR_WIDTH+1)'(w_req_nbytes);
   assign w_req_err    = (int'(bus.req_size) > OFF_W) || (w_req_end > LIMIT);
   assign w_req_split  = (int'(w_req_off) + int'(w_req_nbytes)) > DATA_BYTES;

   // In IDLE the aligner sees the incoming request so ACC0 data can be registered at
   // the handshake; afterwards it sees the latched copy.
   assign w_idle     = (r_state == IDLE);
   assign w_al_off   = w_idle ? w_req_off : r_off;
   assign w_al_size  = w_idle ? size_e'(bus.req_size) : r_size;
   assign w_al_wdata = w_idle ? bus.req_wdata : r_wdata;
   assign w_ld_word  = r_split ? {mem_rdata, r_lo} : {{DATA_WIDTH{1'b0}}, mem_rdata};

   mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .i_off     (w_al_off),
      .i_size    (w_al_size),
      .i_signed  (r_signed),
      .i_wdata   (w_al_wdata),
      .i_ld_word (w_ld_word),
      .o_wen0    (w_wen0),
      .o_wen1    (w_wen1),
      .o_wdata0  (w_wdata0),
      .o_wdata1  (w_wdata1),
      .o_ld_data (w_ld_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_wdata     <= '0;
         r_lo        <= '0;
         r_w0        <= '0;
         r_we        <= 1'b0;
         r_signed    <= 1'b0;
         r_split     <= 1'b0;
         r_size      <= SZ_B;
         r_off       <= '0;
      end else begin
         case (r_state)
            IDLE: if (bus.req_valid) begin
               r_we        <= bus.req_we;
               r_size      <= size_e'(bus.req_size);
               r_signed    <= bus.req_signed;
               r_off       <= w_req_off;
               r_w0        <= w_req_w0;
               r_wdata     <= bus.req_wdata;
               r_split     <= w_req_split;
               r_req_ready <= 1'b0;
               if (w_req_err) begin
                  r_rsp_err   <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= RESP;
               end else begin
                  r_mem_addr  <= w_req_w0;
                  r_mem_wdata <= bus.req_we ? w_wdata0 : '0;
                  r_state     <= ACC0;
               end
            end
            ACC0: if (r_split) begin
               r_mem_addr  <= r_w0 + 1'b1;
               r_mem_wdata <= r_we ? w_wdata1 : '0;
               r_state     <= ACC1;
            end else begin
               r_state <= CAP;
            end
            ACC1: begin
               r_lo    <= mem_rdata;
               r_state <= CAP;
            end
            // The high word goes straight into the assembled response instead of a holding register.
            CAP: begin
               if (!r_split) r_lo <= mem_rdata;
               r_rsp_rdata <= r_we ? '0 : w_ld_data;
               r_rsp_err   <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: if (bus.rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Decoded from state so a write strobe vanishes the instant rst rises.
   always_comb begin
      mem_wen = '0;
      if (r_we && r_state == ACC0) mem_wen = w_wen0;
      else if (r_we && r_state == ACC1) mem_wen = w_wen1;
   end

   assign mem_addr      = r_mem_addr;
   assign mem_wdata     = r_mem_wdata;
   assign bus.req_ready = r_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.rsp_rdata = r_rsp_rdata;
   assign dbg_state     = r_state;
endmodule

// File: tb/tb_mem_sync_sp_lsu.sv
// Directed bench for mem_sync_sp_lsu against a 16x64 write-first synchronous memory model.
module tb_mem_sync_sp_lsu;
   import mem_sync_sp_pkg::*;

   logic       clk;
   logic       rst;
   logic [3:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0] mem_wen;
   logic [63:0] mem_rdata;
   lsu_state_e dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] mem [16] = '{default: 64'h0};
   logic [11:0] wr_q [$];
   logic [63:0] exp_q [$];

   mem_sync_sp_lsu_if #(.DATA_WIDTH(64), .BADDR_WIDTH(7)) bus ();

   mem_sync_sp_lsu #(.DEPTH(16), .DATA_WIDTH(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wen   (mem_wen),
      .mem_rdata (mem_rdata),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
      $fatal(1);
   end

   // ---------------- memory model (1-cycle read, write-first) ----------------
   always @(posedge clk) begin : mem_model
      logic [63:0] nxt;
      nxt = mem[mem_addr];
      for (int b = 0; b < 8; b++) if (mem_wen[b]) nxt[8*b +: 8] = mem_wdata[8*b +: 8];
      if (mem_wen != 8'h00) begin
         mem[mem_addr] <= nxt;
         wr_q.push_back({mem_addr, mem_wen});
      end
      mem_rdata <= nxt;
   end

   // ---------------- driver ----------------
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [6:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata, output logic err, output int lat);
      int guard;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      guard = 0;
      while (bus.req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (bus.rsp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      rdata = bus.rsp_rdata;
      err   = bus.rsp_err;
      if (bus.rsp_valid !== 1'b1) lat = 99;
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2;
      n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0h exp 1", bus.req_ready); end
      n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %0h exp 0", bus.rsp_valid); end
      n_tests++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %0h exp 0", bus.rsp_err); end
      n_tests++; if (bus.rsp_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %0h exp 0", bus.rsp_rdata); end
      n_tests++; if (mem_addr !== 4'h0) begin n_fail++; $display("FAIL reset_mem_addr got %0h exp 0", mem_addr); end
      n_tests++; if (mem_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %0h exp 0", mem_wdata); end
      n_tests++; if (mem_wen !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wen got %0h exp 0", mem_wen); end
      n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %0h exp 1", bus.req_ready); end
   endtask

   task automatic test_dword();
      logic [63:0] rd; logic er; int lat;
      wr_q.delete();
      do_req(1'b1, 2'd3, 1'b0, 7'h08, 64'h0011223344556677, rd, er, lat);
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL sd_latency got %0d exp 3", lat); end
      n_tests++; if (rd !== 64'h0 || er !== 1'b0) begin n_fail++; $display("FAIL sd_ack got rdata %0h err %0h exp 0 0", rd, er); end
      n_tests++; if (wr_q.size() != 1 || wr_q[0] !== {4'd1, 8'hFF}) begin n_fail++; $display("FAIL sd_wen got %0d writes first %0h exp 1 write 1ff", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 12'h0); end
      do_req(1'b0, 2'd3, 1'b0, 7'h08, 64'h0, rd, er, lat);
      n_tests++; if (rd !== 64'h0011223344556677) begin n_fail++; $display("FAIL ld_data got %0h exp 0011223344556677", rd); end
      n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL ld_latency got %0d exp 3", lat); end
   endtask

   task automatic test_byte();
      logic [63:0] rd; logic er; int lat;
      wr_q.delete();
      do_req(1'b1, 2'd0, 1'b0, 7'h13, 64'h80, rd, er, lat);
      n_tests++; if (wr_q.size() != 1 || wr_q[0] !== {4'd2, 8'b0000_1000}) begin n_fail++; $display("FAIL sb_wen got %0d writes first %0h exp 1 write 208", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 12'h0); end
      do_req(1'b0, 2'd0, 1'b1, 7'h13, 64'h0, rd, er, lat);
      n_tests++; if (rd !== 64'hFFFFFFFFFFFFFF80) begin n_fail++; $display("FAIL lb_signed got %0h exp ffffffffffffff80", rd); end
      do_req(1'b0, 2'd0, 1'b0, 7'h13, 64'h0, rd, er, lat);
      n_tests++; if (rd !== 64'h80) begin n_fail++; $display("FAIL lbu got %0h exp 80", rd); end
   endtask

   task automatic test_split();
      logic [63:0] rd; logic er; int lat;
      wr_q.delete();
      do_req(1'b1, 2'd2, 1'b0, 7'h0E, 64'hDEADBEEF, rd, er, lat);
      n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL sw_split_latency got %0d exp 4", lat); end
      n_tests++; if (wr_q.size() != 2 || wr_q[0] !== {4'd1, 8'hC0} || wr_q[1] !== {4'd2, 8'h03}) begin n_fail++; $display("FAIL sw_split_wen got %0d writes exp 1c0 then 203", wr_q.size()); end
      do_req(1'b0, 2'd2, 1'b1, 7'h0E, 64'h0, rd, er, lat);
      n_tests++; if (rd !== 64'hFFFFFFFFDEADBEEF) begin n_fail++; $display("FAIL lw_split got %0h exp ffffffffdeadbeef", rd); end
      n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL lw_split_latency got %0d exp 4", lat); end
      do_req(1'b0, 2'd3, 1'b0, 7'h08, 64'h0, rd, er, lat);
      n_tests++; if (rd !== 64'hBEEF223344556677) begin n_fail++; $display("FAIL ld_after_split got %0h exp beef223344556677", rd); end
      do_req(1'b0, 2'd1, 1'b1, 7'h0F, 64'h0, rd, er, lat);
      n_tests++; if (rd !== 64'hFFFFFFFFFFFFADBE) begin n_fail++; $display("FAIL lh_split_off7 got %0h exp ffffffffffffadbe", rd); end
      do_req(1'b0, 2'd2, 1'b0, 7'h10, 64'h0, rd, er, lat);
      n_tests++; if (rd !== 64'h000000008000DEAD) begin n_fail++; $display("FAIL lwu_word2 got %0h exp 8000dead", rd); end
      do_req(1'b0, 2'd2, 1'b1, 7'h10, 64'h0, rd, er, lat);
      n_tests++; if (rd !== 64'hFFFFFFFF8000DEAD) begin n_fail++; $display("FAIL lw_word2 got %0h exp ffffffff8000dead", rd); end
   endtask

   task automatic test_error();
      logic [63:0] rd; logic er; int lat;
      wr_q.delete();
      do_req(1'b0, 2'd3, 1'b0, 7'h7C, 64'h0, rd, er, lat);
      n_tests++; if (er !== 1'b1 || rd !== 64'h0) begin n_fail++; $display("FAIL ld_oob got err %0h rdata %0h exp 1 0", er, rd); end
      n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL ld_oob_latency got %0d exp 1", lat); end
      do_req(1'b1, 2'd3, 1'b0, 7'h7C, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL sd_oob_err got %0h exp 1", er); end
      n_tests++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL oob_no_write got %0d writes exp 0", wr_q.size()); end
      do_req(1'b0, 2'd1, 1'b0, 7'h7F, 64'h0, rd, er, lat);
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL lh_7f_err got %0h exp 1", er); end
      do_req(1'b0, 2'd0, 1'b0, 7'h7F, 64'h0, rd, er, lat);
      n_tests++; if (er !== 1'b0 || lat !== 3) begin n_fail++; $display("FAIL lb_7f got err %0h lat %0d exp 0 3", er, lat); end
      do_req(1'b0, 2'd3, 1'b0, 7'h78, 64'h0, rd, er, lat);
      n_tests++; if (er !== 1'b0 || rd !== 64'h0) begin n_fail++; $display("FAIL ld_last_word got err %0h rdata %0h exp 0 0", er, rd); end
   endtask

   task automatic test_hold();
      int guard;
      wr_q.delete();
      @(negedge clk);
      bus.rsp_ready  = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd3;
      bus.req_signed = 1'b0;
      bus.req_addr   = 7'h08;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      guard = 0;
      while (bus.rsp_valid !== 1'b1 && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      n_tests++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_rsp_arrives got %0h exp 1", bus.rsp_valid); end
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd0;
      bus.req_addr  = 7'h00;
      bus.req_wdata = 64'h55;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         n_tests++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 64'hBEEF223344556677) begin n_fail++; $display("FAIL hold_stable cycle %0d got valid %0h rdata %0h exp 1 beef223344556677", c, bus.rsp_valid, bus.rsp_rdata); end
         n_tests++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_req_ready cycle %0d got %0h exp 0", c, bus.req_ready); end
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      n_tests++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || dbg_state !== IDLE) begin n_fail++; $display("FAIL hold_release got valid %0h ready %0h state %0d exp 0 1 0", bus.rsp_valid, bus.req_ready, dbg_state); end
      n_tests++; if (wr_q.size() != 0 || mem[0] !== 64'h0) begin n_fail++; $display("FAIL hold_req_ignored got %0d writes mem0 %0h exp 0 0", wr_q.size(), mem[0]); end
   endtask

   task automatic test_reset_mid_split();
      logic [63:0] rd; logic er; int lat;
      wr_q.delete();
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_size   = 2'd2;
      bus.req_signed = 1'b0;
      bus.req_addr   = 7'h1E;
      bus.req_wdata  = 64'h11223344;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clk);
      #2;
      n_tests++; if (dbg_state !== ACC1 || mem_wen !== 8'h03 || mem_addr !== 4'd4) begin n_fail++; $display("FAIL midsplit_acc1 got state %0d wen %0h addr %0h exp 2 03 4", dbg_state, mem_wen, mem_addr); end
      rst = 1'b1;
      #1;
      n_tests++; if (mem_wen !== 8'h00 || dbg_state !== IDLE || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midsplit_rst got wen %0h state %0d valid %0h exp 0 0 0", mem_wen, dbg_state, bus.rsp_valid); end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (mem[4] !== 64'h0 || mem[3] !== 64'h3344000000000000) begin n_fail++; $display("FAIL midsplit_mem got w3 %0h w4 %0h exp 3344000000000000 0", mem[3], mem[4]); end
      n_tests++; if (wr_q.size() != 1) begin n_fail++; $display("FAIL midsplit_writes got %0d exp 1", wr_q.size()); end
      do_req(1'b0, 2'd2, 1'b0, 7'h1C, 64'h0, rd, er, lat);
      n_tests++; if (rd !== 64'h33440000 || lat !== 3) begin n_fail++; $display("FAIL after_rst_load got %0h lat %0d exp 33440000 3", rd, lat); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] rd; logic er; int lat;
      logic [6:0] ld_addr [4];
      logic [1:0] ld_size [4];
      logic       ld_sgn  [4];
      logic [63:0] exp;
      ld_addr = '{7'h29, 7'h2F, 7'h30, 7'h28};
      ld_size = '{2'd1, 2'd1, 2'd0, 2'd3};
      ld_sgn  = '{1'b1, 1'b1, 1'b1, 1'b0};
      exp_q.push_back(64'h0000000000001234);
      exp_q.push_back(64'hFFFFFFFFFFFFFEDC);
      exp_q.push_back(64'hFFFFFFFFFFFFFFFE);
      exp_q.push_back(64'hDC00000000123400);
      do_req(1'b1, 2'd1, 1'b0, 7'h29, 64'h1234, rd, er, lat);
      do_req(1'b1, 2'd1, 1'b0, 7'h2F, 64'hFEDC, rd, er, lat);
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, ld_size[i], ld_sgn[i], ld_addr[i], 64'h0, rd, er, lat);
         exp = exp_q.pop_front();
         n_tests++; if (rd !== exp || er !== 1'b0) begin n_fail++; $display("FAIL b2b_load %0d got %0h err %0h exp %0h 0", i, rd, er, exp); end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 7'h0;
      bus.req_wdata  = 64'h0;
      bus.rsp_ready  = 1'b1;
      test_reset();
      test_dword();
      test_byte();
      test_split();
      test_error();
      test_hold();
      test_reset_mid_split();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
